spi_reg_target: RTL

SPI target (mode 0) that lets an external controller (board MCU or host bridge) read and write ZXUNO registers over a 4-wire link. It is the responder-side counterpart of the core's SPI master used for flash/SD. It oversamples the SPI pins in the system clock domain, decodes a simple opcode/address/data frame, and issues single-cycle register strobes into the ZXUNO register bus.

---
 rtl/spi_reg_target_pkg.sv | 22 ++
 rtl/spi_reg_target_if.sv | 14 +
 rtl/spi_reg_target_pin_sync.sv | 52 +++++
 rtl/spi_reg_target.sv | 130 +++++++++++++
 4 files changed

// File: rtl/spi_reg_target_pkg.sv
// Shared types, opcodes and FSM encodings for the SPI register target.
package spi_reg_target_pkg;

    typedef logic [7:0] spi_byte_t;

    typedef enum logic [1:0] {
        XFER_NONE,
        XFER_WRITE,
        XFER_READ
    } xfer_kind_t;

    localparam spi_byte_t OPC_WRITE_DEF = 8'h02;
    localparam spi_byte_t OPC_READ_DEF  = 8'h03;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_OPCODE = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_WDATA  = 3'd3;
    localparam logic [2:0] ST_RDATA  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

endpackage

// File: rtl/spi_reg_target_if.sv
// ZXUNO register bus as seen from the SPI target (master) and register file (slave).
interface spi_reg_target_if;
    import spi_reg_target_pkg::*;

    spi_byte_t reg_addr;
    spi_byte_t reg_wdata;
    spi_byte_t reg_rdata;
    logic      reg_wr;
    logic      reg_rd;

    modport master (output reg_addr, reg_wdata, reg_wr, reg_rd, input reg_rdata);
    modport slave  (input reg_addr, reg_wdata, reg_wr, reg_rd, output reg_rdata);

endinterface

// File: rtl/spi_reg_target_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus a one-flop SCLK edge detector.
module spi_reg_target_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n_pin,
    input  logic sclk_pin,
    input  logic mosi_pin,
    output logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi,
    output logic sync_vld
);
    logic cs_n_p0, cs_n_p1;
    logic sclk_p0, sclk_p1, sclk_p2;
    logic mosi_p0, mosi_p1;
    logic vld_p0, vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            // stage p0/p1: metastability filter
            cs_n_p0 <= cs_n_pin;
            cs_n_p1 <= cs_n_p0;
            sclk_p0 <= sclk_pin;
            sclk_p1 <= sclk_p0;
            mosi_p0 <= mosi_pin;
            mosi_p1 <= mosi_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            // stage p2: edge-detect history
            sclk_p2 <= sclk_p1;
        end
    end

    // sync_vld marks the first cycle whose synced levels came from the pins, not reset values.
    assign cs_n      = cs_n_p1;
    assign mosi      = mosi_p1;
    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign sync_vld  = vld_p1;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 target that decodes opcode/address/data frames into ZXUNO register strobes.
module spi_reg_target
    import spi_reg_target_pkg::*;
#(
    parameter spi_byte_t OPC_WRITE = OPC_WRITE_DEF,
    parameter spi_byte_t OPC_READ  = OPC_READ_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_cs_n,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic             frame_active,
    spi_reg_target_if.master bus
);
    logic       cs_n_s, sclk_rise, sclk_fall, mosi_s, sync_vld;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    spi_byte_t  rx_sh, tx_sh;
    logic       byte_vld_p3;
    logic       armed;
    xfer_kind_t kind;

    spi_reg_target_pin_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n_pin  (spi_cs_n),
        .sclk_pin  (spi_sclk),
        .mosi_pin  (spi_mosi),
        .cs_n      (cs_n_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi      (mosi_s),
        .sync_vld  (sync_vld)
    );

    // stage p3: receive shifter and byte completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 3'd0;
            rx_sh       <= '0;
            byte_vld_p3 <= 1'b0;
        end else begin
            byte_vld_p3 <= 1'b0;
            if (cs_n_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                rx_sh       <= {rx_sh[6:0], mosi_s};
                bit_cnt     <= bit_cnt + 3'd1;
                byte_vld_p3 <= (bit_cnt == 3'd7);
            end
        end
    end

    // stage p4: frame FSM and register strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            kind          <= XFER_NONE;
            armed         <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_wr    <= 1'b0;
            bus.reg_rd    <= 1'b0;
        end else begin
            bus.reg_wr <= 1'b0;
            bus.reg_rd <= 1'b0;
            // Only a genuinely observed CS-high arms the target; a frame already running at reset is skipped.
            if (sync_vld && cs_n_s)
                armed <= 1'b1;
            if (cs_n_s) begin
                state <= ST_IDLE;
                kind  <= XFER_NONE;
            end else begin
                case (state)
                    ST_IDLE:   state <= armed ? ST_OPCODE : ST_IGNORE;
                    ST_OPCODE: if (byte_vld_p3) begin
                        if (rx_sh == OPC_WRITE) begin
                            state <= ST_ADDR;
                            kind  <= XFER_WRITE;
                        end else if (rx_sh == OPC_READ) begin
                            state <= ST_ADDR;
                            kind  <= XFER_READ;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    ST_ADDR:   if (byte_vld_p3) begin
                        bus.reg_addr <= rx_sh;
                        if (kind == XFER_READ) begin
                            bus.reg_rd <= 1'b1;
                            state      <= ST_RDATA;
                        end else begin
                            state <= ST_WDATA;
                        end
                    end
                    ST_WDATA:  if (byte_vld_p3) begin
                        bus.reg_wdata <= rx_sh;
                        bus.reg_wr    <= 1'b1;
                    end
                    ST_RDATA:  if (byte_vld_p3)
                        bus.reg_rd <= 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    // stage p5: transmit shifter and MISO pad
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh       <= '0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
        end else begin
            spi_miso_oe <= ~cs_n_s;
            // The fall right after a byte boundary must not shift: bit 7 of the new byte is already on MISO.
            if (bus.reg_rd)
                tx_sh <= bus.reg_rdata;
            else if (sclk_fall && !cs_n_s && bit_cnt != 3'd0)
                tx_sh <= {tx_sh[6:0], 1'b1};
            spi_miso <= (state == ST_RDATA) ? tx_sh[7] : 1'b1;
        end
    end

    assign frame_active = ~cs_n_s & (state != ST_IDLE);

endmodule
